alu_seq_unit: RTL

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_decode.sv | 78 +++++++
 rtl/alu_seq_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Opcodes, FSM state encoding and Flag bit positions shared by
//               the sequential ALU and its decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam int unsigned c_OP_ADD = 0;
    localparam int unsigned c_OP_SUB = 1;
    localparam int unsigned c_OP_AND = 2;
    localparam int unsigned c_OP_OR  = 3;
    localparam int unsigned c_OP_XOR = 4;
    localparam int unsigned c_OP_NOT = 5;
    localparam int unsigned c_OP_SLL = 6;
    localparam int unsigned c_OP_SRL = 7;
    localparam int unsigned c_OP_SRA = 8;
    localparam int unsigned c_OP_ROL = 9;
    localparam int unsigned c_OP_MUL = 10;

    localparam int unsigned c_FLAG_USE_CARRY = 0;
    localparam int unsigned c_FLAG_HOLD      = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_decode.sv
// ============================================================================
// Module      : alu_seq_decode
// Description : Combinational opcode decode and single-cycle datapath
//               (add/sub with carry, logic, shifts, rotate, pass-through).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic [OPW-1:0]   aluOp,
    input  logic [1:0]       flag,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             carryIn,
    output logic [WIDTH-1:0] result,
    output logic             carryOut
);

    localparam int c_SHW = $clog2(WIDTH);

    logic [c_SHW-1:0] w_amt;
    logic [c_SHW-1:0] w_idxLeft;
    logic [c_SHW-1:0] w_idxRight;
    logic             w_amtZero;
    logic             w_isSub;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;

    // WIDTH is a power of two, so WIDTH-amt wraps naturally in c_SHW bits.
    assign w_amt      = opB[c_SHW-1:0];
    assign w_idxLeft  = {c_SHW{1'b0}} - w_amt;
    assign w_idxRight = w_amt - {{(c_SHW-1){1'b0}}, 1'b1};
    assign w_amtZero  = (w_amt == {c_SHW{1'b0}});

    always_comb begin
        w_isSub  = (aluOp == OPW'(c_OP_SUB));
        // Subtract is A + ~B + cin: plain SUB uses cin=1, SBC uses the stored carry.
        w_cin    = flag[c_FLAG_USE_CARRY] ? carryIn : w_isSub;
        w_sum    = {1'b0, opA} + {1'b0, (w_isSub ? ~opB : opB)} + {{WIDTH{1'b0}}, w_cin};
        result   = opA;
        carryOut = carryIn;
        case (aluOp)
            OPW'(c_OP_ADD), OPW'(c_OP_SUB): begin
                result   = w_sum[WIDTH-1:0];
                carryOut = w_sum[WIDTH];
            end
            OPW'(c_OP_AND): result = opA & opB;
            OPW'(c_OP_OR):  result = opA | opB;
            OPW'(c_OP_XOR): result = opA ^ opB;
            OPW'(c_OP_NOT): result = ~opA;
            OPW'(c_OP_SLL): begin
                result = opA << w_amt;
                if (!w_amtZero) carryOut = opA[w_idxLeft];
            end
            OPW'(c_OP_SRL): begin
                result = opA >> w_amt;
                if (!w_amtZero) carryOut = opA[w_idxRight];
            end
            OPW'(c_OP_SRA): begin
                result = $signed(opA) >>> w_amt;
                if (!w_amtZero) carryOut = opA[w_idxRight];
            end
            OPW'(c_OP_ROL): begin
                result = (opA << w_amt) | (opA >> w_idxLeft);
                if (!w_amtZero) carryOut = opA[w_idxLeft];
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq_unit.sv
// ============================================================================
// Module      : alu_seq_unit
// Description : Sequential ALU with valid/ready handshake, registered result
//               and flags; optional shift-add multiplier (macro ALU_SEQ_MUL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   AluOp,
    input  logic [1:0]       Flag,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             ZeroFlag,
    output logic             CarryFlag,
    output logic             Busy
);

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic [WIDTH-1:0] w_decResult;
    logic             w_decCarry;
    logic             w_accept;
    logic             w_isMul;
    logic             w_mulLast;

    alu_seq_decode #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_decode (
        .aluOp    (AluOp),
        .flag     (Flag),
        .opA      (OpA),
        .opB      (OpB),
        .carryIn  (r_carry),
        .result   (w_decResult),
        .carryOut (w_decCarry)
    );

`ifdef ALU_SEQ_MUL_EN
    localparam int c_CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_mulA;
    logic [WIDTH-1:0] r_mulB;
    logic [WIDTH-1:0] r_acc;
    logic [c_CW-1:0]  r_mulCnt;
    logic             r_mulHold;
    logic [WIDTH-1:0] w_accNext;

    assign w_isMul   = (AluOp == OPW'(c_OP_MUL));
    assign w_accNext = r_acc + (r_mulB[0] ? r_mulA : {WIDTH{1'b0}});
    assign w_mulLast = (r_mulCnt == c_CW'(WIDTH - 1));
`else
    assign w_isMul   = 1'b0;
    assign w_mulLast = 1'b0;
`endif

    assign w_accept = in_valid && (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        Busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                Busy     = 1'b0;
                if (in_valid) w_stateNext = w_isMul ? ST_MUL : ST_DONE;
            end
            ST_MUL:  if (w_mulLast) w_stateNext = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_stateNext = ST_IDLE;
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= {WIDTH{1'b0}};
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_mulA    <= {WIDTH{1'b0}};
            r_mulB    <= {WIDTH{1'b0}};
            r_acc     <= {WIDTH{1'b0}};
            r_mulCnt  <= {c_CW{1'b0}};
            r_mulHold <= 1'b0;
`endif
        end else begin
            if (w_accept && !w_isMul) begin
                r_result <= w_decResult;
                if (!Flag[c_FLAG_HOLD]) begin
                    r_zero  <= (w_decResult == {WIDTH{1'b0}});
                    r_carry <= w_decCarry;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            if (w_accept && w_isMul) begin
                r_mulA    <= OpA;
                r_mulB    <= OpB;
                r_acc     <= {WIDTH{1'b0}};
                r_mulCnt  <= {c_CW{1'b0}};
                r_mulHold <= Flag[c_FLAG_HOLD];
            end
            // One multiplier bit per cycle; the final partial sum goes straight to Result.
            if (r_state == ST_MUL) begin
                r_acc    <= w_accNext;
                r_mulA   <= r_mulA << 1;
                r_mulB   <= r_mulB >> 1;
                r_mulCnt <= r_mulCnt + 1'b1;
                if (w_mulLast) begin
                    r_result <= w_accNext;
                    if (!r_mulHold) r_zero <= (w_accNext == {WIDTH{1'b0}});
                end
            end
`endif
        end
    end

    assign Result    = r_result;
    assign ZeroFlag  = r_zero;
    assign CarryFlag = r_carry;

endmodule

`default_nettype wire
